ippro_regfile_mp: RTL
=====================

Name: ippro_regfile_mp

Overview:
Parametrised multi-port register file for the IPPro datapath. It is the generalised successor of the fixed 32x2 quad-port LUT-RAM register file. It provides configurable data width, depth and read-port count, and one synchronous write port with read-back. On reset it runs a hardware clear sweep and reports READY. A write-through bypass can be compiled in. It sits between the decode stage (read addresses) and the writeback stage (write port).

Parameters:
DATA_W, 16, bits per register entry (1..64)
DEPTH, 32, number of entries (2..256, need not be a power of two)
NUM_RD, 3, number of asynchronous read ports (1..8)
INIT_VAL, 0, value written to every entry by the clear sweep (DATA_W bits)

Ports:
WCLK  in  1  single clock; all state updates on the rising edge
RST  in  1  synchronous, active-high reset
WE  in  1  write enable; sampled at WCLK
WADDR  in  AW  write / read-back address, where AW = clog2(DEPTH)
WDATA  in  DATA_W  write data
WRDATA  out  DATA_W  asynchronous read-back of mem[WADDR]
RADDR  in  NUM_RD*AW  packed read addresses; port i uses bits [i*AW +: AW]
RDATA  out  NUM_RD*DATA_W  packed asynchronous read data; port i uses bits [i*DATA_W +: DATA_W]
READY  out  1  high once the clear sweep is complete
WR_LOST  out  1  sticky flag: a write was attempted while not READY

Behaviour:
- Two-state FSM: CLEAR and RUN. An AW-bit sweep counter clr_cnt drives the clear.
- While RST=1 at an edge:
  - state <= CLEAR, clr_cnt <= 0, WR_LOST <= 0.
  - No memory write takes place.
  - This applies equally mid-sweep and mid-operation; the reset takes effect at that edge.
- CLEAR, RST=0, each edge:
  - mem[clr_cnt] <= INIT_VAL, clr_cnt <= clr_cnt+1.
  - When clr_cnt==DEPTH-1: state <= RUN.
  - READY rises exactly DEPTH edges after the first edge with RST=0.
- CLEAR with WE=1:
  - The write is dropped and WR_LOST <= 1.
  - The flag clears only on RST.
- RUN with WE=1 and WADDR<DEPTH: mem[WADDR] <= WDATA at the edge.
- RUN with WE=1 and WADDR>=DEPTH: the write is ignored. No flag is set.
- Reads:
  - Combinational. RDATA port i = mem[RADDR_i].
  - Any port addressing >=DEPTH returns 0.
  - WRDATA follows the same rule for WADDR.
- Read outputs while READY=0: all RDATA and WRDATA are forced to 0.
- Read-during-write (bypass macro undefined):
  - In the write cycle a reader sees the old value.
  - The new value is visible from the cycle after the edge.
- Any number of read ports may address the same entry, including WADDR. There is no arbitration.
- Reset values: READY=0, WR_LOST=0, RDATA=0, WRDATA=0.
- Memory contents are undefined until the sweep completes. The forced-zero read outputs make this invisible.
- Latency: read 0 cycles (combinational); write 1 edge.

Optional Feature:
Macro IPPRO_RF_BYPASS_EN.
- Defined: in RUN, when WE=1, WADDR<DEPTH and RADDR_i==WADDR, RDATA port i = WDATA combinationally in that same cycle (write-through forwarding). WRDATA = WDATA likewise.
- Undefined: old-value-in-write-cycle semantics as above.
- Neither setting applies bypass during CLEAR.

Decomposition:
- Package ippro_rf_pkg holds:
  - clog2 function
  - state encodings ST_CLEAR=1'b0, ST_RUN=1'b1
  - default parameter constants
- Sub-module ippro_rf_init_ctrl holds the FSM, clr_cnt, READY and WR_LOST. Its outputs are:
  - clear-write enable
  - clear address
  - a gate that the top uses to mux write address/data and to block the user WE
- The top holds the memory array and the read muxes, built with a generate loop over NUM_RD.

Test Plan:
1. Sweep timing: RST high 3 cycles then low, DEPTH=32, INIT_VAL=16'hA5A5 -> READY rises on edge 32 after RST falls. All RDATA read 0 before READY and 16'hA5A5 after.
2. Write/read: write addr 5 = 16'h1234, addr 31 = 16'hBEEF. Then RADDR={31,5,5} -> RDATA ports {0,1,2} = {1234,1234,BEEF}. WRDATA at WADDR=5 = 1234.
3. Early write: WE=1 at cycle 10 of the sweep -> write dropped, WR_LOST=1 and held. After READY the entry reads INIT_VAL. Asserting RST clears WR_LOST.
4. Read-during-write at addr 7 (old value 16'h0001, new 16'h0002): without the macro, same-cycle RDATA=0001 and next cycle 0002. With IPPRO_RF_BYPASS_EN, same-cycle RDATA=0002.
5. Non-power-of-2 depth: DEPTH=20, write to addr 25 -> ignored. RADDR=25 -> 0. Addr 19 writes and reads normally.
6. Mid-operation reset: in RUN, pulse RST 1 cycle -> READY=0 on that edge and the sweep restarts from 0. Previously written data reads INIT_VAL after READY returns.

Source files
------------

// File: rtl/ippro_rf_pkg.sv
// Shared definitions for the IPPro multi-port register file:
// default parameter values, FSM state encodings and a ceil-log2 helper.
package ippro_rf_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_DEPTH  = 32;
  localparam int DEF_NUM_RD = 3;

  // Init controller states: CLEAR sweeps INIT_VAL into memory, RUN serves user traffic.
  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  // Ceil(log2(value)); used for address widths. DEPTH is always >= 2 here,
  // so the result is at least 1.
  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/ippro_rf_init_ctrl.sv
// Init controller for ippro_regfile_mp: runs the post-reset clear sweep,
// reports READY, and records writes attempted before READY (WR_LOST).
module ippro_rf_init_ctrl
  import ippro_rf_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  output logic          clr_we,    // write INIT_VAL at clr_addr this edge
  output logic [AW-1:0] clr_addr,
  output logic          clr_sel,   // memory port owned by the controller, user write blocked
  output logic          ready,
  output logic          wr_lost
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  logic [0:0]    state_q, state_d;
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;
  logic          wr_lost_q, wr_lost_d;

  // Next-state logic: advance the sweep while clearing, latch any early write attempt.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    wr_lost_d = wr_lost_q;
    if (state_q == ST_CLEAR) begin
      clr_cnt_d = clr_cnt_q + AW'(1);
      if (we) wr_lost_d = 1'b1;
      if (clr_cnt_q == LAST_ADDR) state_d = ST_RUN;
    end
  end

  // State registers with synchronous reset back to the start of the sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
      wr_lost_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      wr_lost_q <= wr_lost_d;
    end
  end

  // Reset also takes the memory port away from the user so no write lands on a reset edge.
  assign clr_sel  = rst || (state_q == ST_CLEAR);
  assign clr_we   = !rst && (state_q == ST_CLEAR);
  assign clr_addr = clr_cnt_q;
  assign ready    = (state_q == ST_RUN);
  assign wr_lost  = wr_lost_q;

endmodule

// File: rtl/ippro_regfile_mp.sv
// Parametrised multi-port register file for the IPPro datapath: one synchronous
// write port with asynchronous read-back, NUM_RD asynchronous read ports, and a
// hardware clear sweep after reset.
// Optional macro IPPRO_RF_BYPASS_EN: forward WDATA to any same-cycle reader of WADDR.
module ippro_regfile_mp
  import ippro_rf_pkg::*;
#(
  parameter int                DATA_W   = DEF_DATA_W,
  parameter int                DEPTH    = DEF_DEPTH,
  parameter int                NUM_RD   = DEF_NUM_RD,
  parameter logic [DATA_W-1:0] INIT_VAL = '0,
  localparam int               AW       = clog2(DEPTH)
) (
  input  logic                     WCLK,
  input  logic                     RST,
  input  logic                     WE,
  input  logic [AW-1:0]            WADDR,
  input  logic [DATA_W-1:0]        WDATA,
  output logic [DATA_W-1:0]        WRDATA,
  input  logic [NUM_RD*AW-1:0]     RADDR,
  output logic [NUM_RD*DATA_W-1:0] RDATA,
  output logic                     READY,
  output logic                     WR_LOST
);

  localparam logic [AW:0] DEPTH_X = (AW + 1)'(DEPTH);

  // DEPTH need not be a power of two, so addresses are range-checked explicitly.
  function automatic logic in_range(input logic [AW-1:0] a);
    return {1'b0, a} < DEPTH_X;
  endfunction

  logic              clr_we;
  logic [AW-1:0]     clr_addr;
  logic              clr_sel;
  logic              ready;
  logic              user_we;
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_q [DEPTH];

  ippro_rf_init_ctrl #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_init_ctrl (
    .clk      (WCLK),
    .rst      (RST),
    .we       (WE),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .clr_sel  (clr_sel),
    .ready    (ready),
    .wr_lost  (WR_LOST)
  );

  assign READY   = ready;
  // Out-of-range user writes are silently ignored.
  assign user_we = WE && in_range(WADDR) && !clr_sel;

  // Select the single memory write port between the clear sweep and the user.
  always_comb begin
    mem_we    = user_we;
    mem_addr  = WADDR;
    mem_wdata = WDATA;
    if (clr_sel) begin
      mem_we    = clr_we;
      mem_addr  = clr_addr;
      mem_wdata = INIT_VAL;
    end
  end

  // Storage: one write per edge, no reset (contents are hidden until the sweep ends).
  always_ff @(posedge WCLK) begin
    if (mem_we) mem_q[mem_addr] <= mem_wdata;
  end

  // Read-back port: same rules as the read ports, addressed by WADDR.
  always_comb begin
    WRDATA = '0;
    if (ready && in_range(WADDR)) begin
      WRDATA = mem_q[WADDR];
`ifdef IPPRO_RF_BYPASS_EN
      if (user_we) WRDATA = WDATA;
`endif
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [AW-1:0]     ra;
      logic [DATA_W-1:0] rd;

      assign ra = RADDR[gi*AW +: AW];

      // Read port gi: zero while not ready or out of range, otherwise the stored word.
      always_comb begin
        rd = '0;
        if (ready && in_range(ra)) begin
          rd = mem_q[ra];
`ifdef IPPRO_RF_BYPASS_EN
          if (user_we && (ra == WADDR)) rd = WDATA;
`endif
        end
      end

      assign RDATA[gi*DATA_W +: DATA_W] = rd;
    end
  endgenerate

endmodule
